// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin byte scheduler in front of a single UART
//               transmitter, with watchdog abort and sticky timeout error.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_send,
  input  logic                       tx_flag,
  output logic                       tx_flag_clr,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       timeout_err,
  input  logic                       err_clr
);

  localparam int c_id_w = $clog2(NUM_REQ);
  localparam int c_wd_w = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [c_wd_w-1:0] c_wd_last =
    (TIMEOUT_CYCLES > 0) ? c_wd_w'(TIMEOUT_CYCLES - 1) : c_wd_w'(0);
  localparam logic [c_id_w:0]   c_num     = (c_id_w + 1)'(NUM_REQ);
  localparam logic [c_id_w-1:0] c_last_id = c_id_w'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_id_w-1:0]   r_rr_ptr;
  logic [c_id_w-1:0]   r_grant_id;
  logic [c_id_w-1:0]   w_win;
  logic                w_found;
  logic                w_accept;
  logic                w_timeout_hit;
  logic [DATA_W-1:0]   r_tx_data;
  logic [c_wd_w-1:0]   r_wd_cnt;
  logic                r_timeout_err;

  // Scan rr_ptr, rr_ptr+1, ... (mod NUM_REQ) and keep the first valid index.
  always_comb begin : p_arb
    logic [c_id_w:0] v_idx;
    w_found = 1'b0;
    w_win   = '0;
    v_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_idx = {1'b0, r_rr_ptr} + (c_id_w + 1)'(k);
      if (v_idx >= c_num) begin
        v_idx = v_idx - c_num;
      end
      if (!w_found && req_valid[v_idx[c_id_w-1:0]]) begin
        w_found = 1'b1;
        w_win   = v_idx[c_id_w-1:0];
      end
    end
  end

  always_comb begin : p_fsm_comb
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_timeout_hit = 1'b0;
    req_ready     = '0;
    tx_send       = 1'b0;
    tx_flag_clr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A flag left over from an aborted transfer is cleared before any grant.
        if (tx_flag) begin
          w_state_nxt = ST_CLEAR;
        end else if (w_found) begin
          w_accept    = 1'b1;
          req_ready   = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        tx_send     = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_flag) begin
          w_state_nxt = ST_CLEAR;
        end else if ((TIMEOUT_CYCLES != 0) && (r_wd_cnt == c_wd_last)) begin
          w_timeout_hit = 1'b1;
          w_state_nxt   = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        tx_flag_clr = 1'b1;
        if (!tx_flag) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (rst) begin
      req_ready     = '0;
      tx_send       = 1'b0;
      tx_flag_clr   = 1'b0;
      w_accept      = 1'b0;
      w_timeout_hit = 1'b0;
    end
  end

  always_ff @(posedge clk) begin : p_state
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin : p_datapath
    if (rst) begin
      r_tx_data     <= '0;
      r_grant_id    <= '0;
      r_rr_ptr      <= '0;
      r_wd_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_tx_data  <= req_data[w_win*DATA_W +: DATA_W];
        r_grant_id <= w_win;
        r_rr_ptr   <= (w_win == c_last_id) ? '0 : w_win + c_id_w'(1);
        r_wd_cnt   <= '0;
      end else if ((TIMEOUT_CYCLES != 0) && (r_state == ST_WAIT) && !tx_flag &&
                   (r_wd_cnt != c_wd_last)) begin
        r_wd_cnt <= r_wd_cnt + c_wd_w'(1);
      end
      // A timeout in the same cycle as err_clr keeps the error set.
      if (w_timeout_hit) begin
        r_timeout_err <= 1'b1;
      end else if (err_clr) begin
        r_timeout_err <= 1'b0;
      end
    end
  end

  assign tx_data     = r_tx_data;
  assign grant_id    = r_grant_id;
  assign timeout_err = r_timeout_err;
  assign busy        = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int c_timeout = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_flag;
  logic        tx_flag_clr;
  logic        busy;
  logic [0:0]  grant_id;
  logic        timeout_err;
  logic        err_clr;

  int n_checks = 0;
  int n_fail   = 0;
  int n_send   = 0;

  uart_tx_arbiter #(
    .NUM_REQ        (2),
    .DATA_W         (8),
    .TIMEOUT_CYCLES (c_timeout)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_send     (tx_send),
    .tx_flag     (tx_flag),
    .tx_flag_clr (tx_flag_clr),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tx_send) n_send <= n_send + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One byte from IDLE: accept, send, UART flag dly cycles after tx_send, clear, back to IDLE.
  task automatic do_byte(input logic [1:0] valid, input logic [15:0] data,
                         input int exp_id, input logic [7:0] exp_data,
                         input int dly, input bit hold);
    req_valid = valid;
    req_data  = data;
    #1;
    check("ready_grant", req_ready, 2'b01 << exp_id);
    check("idle_busy", busy, 1'b0);
    tick();
    if (!hold) req_valid = 2'b00;
    check("send_pulse", tx_send, 1'b1);
    check("send_data", tx_data, exp_data);
    check("send_gid", grant_id, exp_id);
    check("send_ready0", req_ready, 2'b00);
    tick();
    check("wait_nosend", tx_send, 1'b0);
    repeat (dly - 1) tick();
    tx_flag = 1'b1;
    #1;
    check("wait_noclr", tx_flag_clr, 1'b0);
    tick();
    check("clear_clr", tx_flag_clr, 1'b1);
    tick();
    tx_flag = 1'b0;
    #1;
    check("clear_hold", tx_flag_clr, 1'b1);
    tick();
    check("back_idle", busy, 1'b0);
  endtask

  // Run requester 0 into the watchdog; optionally raise tx_flag and/or err_clr at the hit cycle.
  task automatic do_timeout(input bit flag_at_hit, input bit clr_at_hit, input bit exp_err);
    req_valid = 2'b01;
    req_data  = 16'h005A;
    tick();
    req_valid = 2'b00;
    tick();
    repeat (c_timeout - 1) tick();
    check("wd_still_wait", tx_flag_clr, 1'b0);
    check("wd_busy", busy, 1'b1);
    tx_flag = flag_at_hit;
    err_clr = clr_at_hit;
    tick();
    err_clr = 1'b0;
    check("wd_clear", tx_flag_clr, 1'b1);
    check("wd_err", timeout_err, exp_err);
    if (flag_at_hit) begin
      tick();
      tx_flag = 1'b0;
    end
    tick();
    check("wd_idle", busy, 1'b0);
  endtask

  initial begin
    int sends_before;
    rst       = 1'b1;
    req_valid = 2'b01;
    req_data  = 16'h0000;
    tx_flag   = 1'b0;
    err_clr   = 1'b0;
    #1;
    check("rst_ready", req_ready, 2'b00);
    tick();
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_txdata", tx_data, 8'h00);
    check("rst_gid", grant_id, 1'b0);
    check("rst_err", timeout_err, 1'b0);
    check("rst_send", tx_send, 1'b0);
    check("rst_clr", tx_flag_clr, 1'b0);
    req_valid = 2'b00;
    rst       = 1'b0;
    tick();

    // Single byte, UART completes 20 cycles after tx_send
    do_byte(2'b01, 16'h00A5, 0, 8'hA5, 20, 1'b0);

    // Both valid continuously from rr_ptr=0: alternating grants
    rst = 1'b1;
    tick();
    rst = 1'b0;
    do_byte(2'b11, 16'h2211, 0, 8'h11, 1, 1'b1);
    do_byte(2'b11, 16'h2211, 1, 8'h22, 1, 1'b1);
    do_byte(2'b11, 16'h2211, 0, 8'h11, 1, 1'b1);
    do_byte(2'b11, 16'h2211, 1, 8'h22, 1, 1'b0);

    // Watchdog: plain abort, abort racing err_clr, then clear, then flag at the hit cycle
    do_timeout(1'b0, 1'b0, 1'b1);
    do_timeout(1'b0, 1'b1, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_cleared", timeout_err, 1'b0);
    do_timeout(1'b1, 1'b0, 1'b0);

    // Reset in WAIT while UART holds its flag; pending requester 1
    req_valid = 2'b01;
    req_data  = 16'h7700;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    tx_flag   = 1'b1;
    rst       = 1'b1;
    req_valid = 2'b10;
    #1;
    check("rstw_ready", req_ready, 2'b00);
    check("rstw_clr", tx_flag_clr, 1'b0);
    tick();
    check("rstw_busy", busy, 1'b0);
    check("rstw_send", tx_send, 1'b0);
    check("rstw_txdata", tx_data, 8'h00);
    check("rstw_gid", grant_id, 1'b0);
    rst = 1'b0;
    #1;
    check("stale_noready", req_ready, 2'b00);
    tick();
    check("stale_clr", tx_flag_clr, 1'b1);
    check("stale_gid", grant_id, 1'b0);
    tick();
    tx_flag = 1'b0;
    tick();
    do_byte(2'b10, 16'h7700, 1, 8'h77, 3, 1'b0);

    // Requester 1 alone, three bytes back to back
    sends_before = n_send;
    do_byte(2'b10, 16'h3100, 1, 8'h31, 2, 1'b1);
    do_byte(2'b10, 16'h3200, 1, 8'h32, 2, 1'b1);
    do_byte(2'b10, 16'h3300, 1, 8'h33, 2, 1'b0);
    tick();
    check("three_sends", n_send - sends_before, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
